i2c_write_ctrl: RTL and testbench

I2C_WRITE_CTRL -- requirements
Module: i2c_write_ctrl

---
 rtl/i2c_write_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_i2c_write_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_write_ctrl.sv
// i2c_write_ctrl: queues register-write commands and sequences them onto an
// I2C byte sender as three bytes: {DEV_ADDR, W}, register address, data.
//
// Ports:
//   clk, rst_n          clock; asynchronous active-low reset
//   cmd_valid/cmd_ready command handshake into a 4-entry FIFO
//   cmd_reg, cmd_data   register address and data byte of a write command
//   pre_ready           one-cycle pulse: pre_data holds a byte for the sender
//   pre_data, pre_last  byte to send; pre_last marks the final byte (STOP after)
//   byte_done, byte_ack sender's per-byte completion pulse and sampled ACK
//   busy                a transaction is in progress
//   wr_done, wr_err     one-cycle completion / abort pulses
//   err_code            01 = NACK, 10 = timeout; held until the next wr_err
//   fifo_count          number of queued commands, 0..4
module i2c_write_ctrl #(
    parameter logic [6:0]  DEV_ADDR = 7'h50,
    parameter int unsigned TIMEOUT  = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_reg,
    input  logic [7:0] cmd_data,
    output logic       pre_ready,
    output logic [7:0] pre_data,
    output logic       pre_last,
    input  logic       byte_done,
    input  logic       byte_ack,
    output logic       busy,
    output logic       wr_done,
    output logic       wr_err,
    output logic [1:0] err_code,
    output logic [2:0] fifo_count
);

    // Counter only needs to reach TIMEOUT-1: the timeout fires on the cycle
    // it would have become TIMEOUT.
    localparam int unsigned     CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SEND_A = 3'd1,
        WAIT_A = 3'd2,
        SEND_R = 3'd3,
        WAIT_R = 3'd4,
        SEND_D = 3'd5,
        WAIT_D = 3'd6,
        FIN    = 3'd7
    } state_t;

    // Where an ACKed byte leads from each wait state.
    function automatic state_t ack_next(input state_t s);
        state_t n;
        case (s)
            WAIT_A:  n = SEND_R;
            WAIT_R:  n = SEND_D;
            WAIT_D:  n = FIN;
            default: n = IDLE;
        endcase
        return n;
    endfunction

    state_t           state_r, state_s;
    logic [15:0]      fifo_mem_r [4];
    logic [1:0]       wr_ptr_r, rd_ptr_r;
    logic [2:0]       count_r, count_s;
    logic             cmd_ready_r;
    logic [15:0]      hold_r;
    logic [CNT_W-1:0] tmo_cnt_r;
    logic             push_s, pop_s, is_wait_s;

    logic             pre_ready_r, pre_ready_s;
    logic [7:0]       pre_data_r, pre_data_s;
    logic             pre_last_r, pre_last_s;
    logic             busy_r;
    logic             wr_done_r, wr_done_s;
    logic             wr_err_r, wr_err_s;
    logic [1:0]       err_code_r, err_code_s;

    assign push_s    = cmd_valid && cmd_ready_r;
    assign pop_s     = (state_r == IDLE) && (count_r != 3'd0);
    assign is_wait_s = (state_r == WAIT_A) || (state_r == WAIT_R) || (state_r == WAIT_D);

    assign cmd_ready  = cmd_ready_r;
    assign fifo_count = count_r;
    assign pre_ready  = pre_ready_r;
    assign pre_data   = pre_data_r;
    assign pre_last   = pre_last_r;
    assign busy       = busy_r;
    assign wr_done    = wr_done_r;
    assign wr_err     = wr_err_r;
    assign err_code   = err_code_r;

    // Next FIFO occupancy; a push and pop on the same edge cancel out.
    always_comb begin
        count_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_s = count_r + 3'd1;
            2'b01:   count_s = count_r - 3'd1;
            default: count_s = count_r;
        endcase
    end

    // FIFO storage, wrapping pointers, occupancy and registered ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                fifo_mem_r[i] <= 16'h0000;
            end
            wr_ptr_r    <= 2'd0;
            rd_ptr_r    <= 2'd0;
            count_r     <= 3'd0;
            cmd_ready_r <= 1'b1;
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= {cmd_reg, cmd_data};
                wr_ptr_r             <= wr_ptr_r + 2'd1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 2'd1;
            end
            count_r     <= count_s;
            cmd_ready_r <= (count_s != 3'd4);
        end
    end

    // Holding register for the command currently being sent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_r <= 16'h0000;
        end else if (pop_s) begin
            hold_r <= fifo_mem_r[rd_ptr_r];
        end
    end

    // Per-byte timeout counter: runs only while staying in the same wait
    // state, so it restarts from zero on every wait-state entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_r <= {CNT_W{1'b0}};
        end else if (is_wait_s && (state_s == state_r)) begin
            tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
        end else begin
            tmo_cnt_r <= {CNT_W{1'b0}};
        end
    end

    // Next-state and next-output logic; all outputs are registered below.
    always_comb begin
        state_s     = state_r;
        pre_ready_s = 1'b0;
        pre_data_s  = pre_data_r;
        pre_last_s  = pre_last_r;
        wr_done_s   = 1'b0;
        wr_err_s    = 1'b0;
        err_code_s  = err_code_r;
        case (state_r)
            IDLE: begin
                if (count_r != 3'd0) begin
                    state_s = SEND_A;
                end else begin
                    state_s = IDLE;
                end
            end
            SEND_A: begin
                pre_ready_s = 1'b1;
                pre_data_s  = {DEV_ADDR, 1'b0};
                state_s     = WAIT_A;
            end
            SEND_R: begin
                pre_ready_s = 1'b1;
                pre_data_s  = hold_r[15:8];
                state_s     = WAIT_R;
            end
            SEND_D: begin
                pre_ready_s = 1'b1;
                pre_data_s  = hold_r[7:0];
                pre_last_s  = 1'b1;
                state_s     = WAIT_D;
            end
            WAIT_A, WAIT_R, WAIT_D: begin
                if (byte_done) begin
                    pre_last_s = 1'b0;
                    if (byte_ack) begin
                        state_s   = ack_next(state_r);
                        wr_done_s = (state_r == WAIT_D);
                    end else begin
                        state_s    = IDLE;
                        wr_err_s   = 1'b1;
                        err_code_s = 2'b01;
                    end
                end else if (tmo_cnt_r == TMO_LAST) begin
                    state_s    = IDLE;
                    pre_last_s = 1'b0;
                    wr_err_s   = 1'b1;
                    err_code_s = 2'b10;
                end else begin
                    state_s = state_r;
                end
            end
            FIN: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and output registers. wr_done is raised on entry to FIN so the
    // pulse coincides with the FIN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            pre_ready_r <= 1'b0;
            pre_data_r  <= 8'h00;
            pre_last_r  <= 1'b0;
            busy_r      <= 1'b0;
            wr_done_r   <= 1'b0;
            wr_err_r    <= 1'b0;
            err_code_r  <= 2'b00;
        end else begin
            state_r     <= state_s;
            pre_ready_r <= pre_ready_s;
            pre_data_r  <= pre_data_s;
            pre_last_r  <= pre_last_s;
            busy_r      <= (state_s != IDLE);
            wr_done_r   <= wr_done_s;
            wr_err_r    <= wr_err_s;
            err_code_r  <= err_code_s;
        end
    end

endmodule

// File: tb/tb_i2c_write_ctrl.sv
// Testbench for i2c_write_ctrl: a scoreboard of expected byte/done/error events
// is filled when a command is accepted; a monitor pops and compares whenever
// the DUT pulses pre_ready, wr_done or wr_err. A responder plays the byte
// sender, answering each byte according to the plan stored with its command.
`timescale 1ns/1ps
module tb_i2c_write_ctrl;

    localparam int         TMO  = 20;
    localparam logic [6:0] ADDR = 7'h50;
    localparam int K_BYTE = 0;
    localparam int K_DONE = 1;
    localparam int K_ERR  = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_reg;
    logic [7:0] cmd_data;
    logic       pre_ready;
    logic [7:0] pre_data;
    logic       pre_last;
    logic       byte_done;
    logic       byte_ack;
    logic       busy;
    logic       wr_done;
    logic       wr_err;
    logic [1:0] err_code;
    logic [2:0] fifo_count;

    i2c_write_ctrl #(.DEV_ADDR(ADDR), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_reg(cmd_reg), .cmd_data(cmd_data),
        .pre_ready(pre_ready), .pre_data(pre_data), .pre_last(pre_last),
        .byte_done(byte_done), .byte_ack(byte_ack),
        .busy(busy), .wr_done(wr_done), .wr_err(wr_err),
        .err_code(err_code), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         kind;
        logic [7:0] data;
        logic       last;
        logic [1:0] code;
    } exp_t;

    exp_t exp_q[$];
    int   resp_q[$];   // 1 = ACK, 0 = NACK, 2 = never answer
    bit   hold;
    int   n_checks;
    int   n_fail;
    int   last_pr_cyc;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: a write is three bytes (address+W, register, data),
    // the last flagged; a failing byte ends the transaction with an error.
    task automatic build_txn(input logic [7:0] r, input logic [7:0] d, input int fk, input int fa);
        logic [7:0] bytes [3];
        exp_t e;
        bytes[0] = 8'(ADDR) * 8'd2;
        bytes[1] = r;
        bytes[2] = d;
        for (int i = 0; i < 3; i++) begin
            e.kind = K_BYTE; e.data = bytes[i]; e.last = (i == 2); e.code = 2'b00;
            exp_q.push_back(e);
            if (fk != 0 && i == fa) begin
                resp_q.push_back((fk == 1) ? 0 : 2);
                e.kind = K_ERR; e.data = 8'h00; e.last = 1'b0;
                e.code = (fk == 1) ? 2'b01 : 2'b10;
                exp_q.push_back(e);
                return;
            end
            resp_q.push_back(1);
        end
        e.kind = K_DONE; e.data = 8'h00; e.last = 1'b0; e.code = 2'b00;
        exp_q.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push_cmd(input logic [7:0] r, input logic [7:0] d, input int fk, input int fa);
        int waited = 0;
        cmd_valid = 1'b1; cmd_reg = r; cmd_data = d;
        while (!cmd_ready && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        if (!cmd_ready) begin
            check(1'b0, "push_wait", 32'(cmd_ready), 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        build_txn(r, d, fk, fa);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(exp_q.size() == 0 && busy == 1'b0, "drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset(input string p);
        check(pre_ready == 1'b0,    {p, "_pre_ready"},  32'(pre_ready),  32'd0);
        check(pre_data == 8'h00,    {p, "_pre_data"},   32'(pre_data),   32'd0);
        check(pre_last == 1'b0,     {p, "_pre_last"},   32'(pre_last),   32'd0);
        check(busy == 1'b0,         {p, "_busy"},       32'(busy),       32'd0);
        check(wr_done == 1'b0,      {p, "_wr_done"},    32'(wr_done),    32'd0);
        check(wr_err == 1'b0,       {p, "_wr_err"},     32'(wr_err),     32'd0);
        check(err_code == 2'b00,    {p, "_err_code"},   32'(err_code),   32'd0);
        check(fifo_count == 3'd0,   {p, "_fifo_count"}, 32'(fifo_count), 32'd0);
        check(cmd_ready == 1'b1,    {p, "_cmd_ready"},  32'(cmd_ready),  32'd1);
    endtask

    initial begin
        int cnt;
        int fk;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_reg = 8'h00; cmd_data = 8'h00;
        byte_done = 1'b0; byte_ack = 1'b0; hold = 1'b0;
        n_checks = 0; n_fail = 0; last_pr_cyc = 0;

        fork
            begin : monitor
                exp_t me;
                forever begin
                    @(negedge clk);
                    if (rst_n) begin
                        if (pre_ready) begin
                            last_pr_cyc = cyc;
                            if (exp_q.size() == 0) begin
                                check(1'b0, "unexpected_byte", 32'(pre_data), 32'd0);
                            end else begin
                                me = exp_q.pop_front();
                                check(me.kind == K_BYTE, "byte_order", 32'(me.kind), 32'(K_BYTE));
                                check(pre_data == me.data, "pre_data", 32'(pre_data), 32'(me.data));
                                check(pre_last == me.last, "pre_last", 32'(pre_last), 32'(me.last));
                            end
                        end
                        if (wr_done) begin
                            if (exp_q.size() == 0) begin
                                check(1'b0, "unexpected_done", 32'd1, 32'd0);
                            end else begin
                                me = exp_q.pop_front();
                                check(me.kind == K_DONE, "done_order", 32'(me.kind), 32'(K_DONE));
                            end
                        end
                        if (wr_err) begin
                            if (exp_q.size() == 0) begin
                                check(1'b0, "unexpected_err", 32'(err_code), 32'd0);
                            end else begin
                                me = exp_q.pop_front();
                                check(me.kind == K_ERR, "err_order", 32'(me.kind), 32'(K_ERR));
                                check(err_code == me.code, "err_code", 32'(err_code), 32'(me.code));
                                check(busy == 1'b0, "idle_after_err", 32'(busy), 32'd0);
                                if (me.code == 2'b10) begin
                                    check(cyc - last_pr_cyc == TMO, "timeout_cycles",
                                          32'(cyc - last_pr_cyc), 32'(TMO));
                                end
                            end
                        end
                    end
                end
            end
            begin : responder
                int r;
                int dly;
                forever begin
                    @(negedge clk);
                    if (rst_n && pre_ready && resp_q.size() != 0) begin
                        r = resp_q.pop_front();
                        if (r != 2) begin
                            while (hold) @(negedge clk);
                            dly = $urandom_range(0, 3);
                            repeat (dly) @(negedge clk);
                            byte_done = 1'b1;
                            byte_ack  = (r == 1);
                            @(negedge clk);
                            byte_done = 1'b0;
                            byte_ack  = 1'b0;
                        end
                    end
                end
            end
        join_none

        // Reset state
        repeat (2) @(negedge clk);
        check_reset("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // Single write with latency checks
        push_cmd(8'h12, 8'hA5, 0, 0);
        check(fifo_count == 3'd1, "lat_count_push", 32'(fifo_count), 32'd1);
        check(busy == 1'b0, "lat_busy_push", 32'(busy), 32'd0);
        @(negedge clk);
        check(fifo_count == 3'd0, "lat_count_pop", 32'(fifo_count), 32'd0);
        check(busy == 1'b1, "lat_busy_pop", 32'(busy), 32'd1);
        check(pre_ready == 1'b0, "lat_early_ready", 32'(pre_ready), 32'd0);
        @(negedge clk);
        check(pre_ready == 1'b1, "lat_pre_ready", 32'(pre_ready), 32'd1);
        check(pre_data == 8'hA0, "lat_pre_data", 32'(pre_data), 32'hA0);
        wait_idle(300);

        // NACK on the address byte
        push_cmd(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1, 0);
        wait_idle(300);
        check(err_code == 2'b01, "nack_code_hold", 32'(err_code), 32'd1);

        // Timeout on the address byte
        push_cmd(8'h34, 8'h56, 2, 0);
        wait_idle(300);
        check(err_code == 2'b10, "tmo_code_hold", 32'(err_code), 32'd2);

        // Stray byte_done while idle is ignored
        repeat (3) begin
            @(negedge clk);
            byte_done = 1'b1;
            byte_ack  = 1'($urandom_range(0, 1));
            @(negedge clk);
            byte_done = 1'b0;
            byte_ack  = 1'b0;
        end
        repeat (4) @(negedge clk);
        check(busy == 1'b0, "stray_busy", 32'(busy), 32'd0);
        check(err_code == 2'b10, "stray_code", 32'(err_code), 32'd2);

        // FIFO full while the head waits for its address byte
        hold = 1'b1;
        push_cmd(8'h01, 8'h11, 0, 0);
        repeat (2) @(negedge clk);
        for (int k = 1; k <= 4; k++) begin
            push_cmd(8'(8'h01 + k), 8'(8'h11 * (k + 1)), 0, 0);
            check(fifo_count == 3'(k), "full_count", 32'(fifo_count), 32'(k));
        end
        cmd_valid = 1'b1; cmd_reg = 8'hEE; cmd_data = 8'hEE;
        check(cmd_ready == 1'b0, "full_ready", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        cmd_valid = 1'b0;
        check(fifo_count == 3'd4, "full_refused", 32'(fifo_count), 32'd4);
        hold = 1'b0;
        wait_idle(1000);

        // Push on the same edge that IDLE pops with two queued
        hold = 1'b1;
        push_cmd(8'h21, 8'h31, 0, 0);
        push_cmd(8'h22, 8'h32, 0, 0);
        push_cmd(8'h23, 8'h33, 0, 0);
        hold = 1'b0;
        cnt = 0;
        while (!wr_done && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        check(wr_done == 1'b1, "pp_done_seen", 32'(wr_done), 32'd1);
        @(negedge clk);
        check(fifo_count == 3'd2, "pp_before", 32'(fifo_count), 32'd2);
        check(busy == 1'b0, "pp_idle", 32'(busy), 32'd0);
        cmd_valid = 1'b1; cmd_reg = 8'h24; cmd_data = 8'h34;
        build_txn(8'h24, 8'h34, 0, 0);
        @(negedge clk);
        cmd_valid = 1'b0;
        check(fifo_count == 3'd2, "pp_after", 32'(fifo_count), 32'd2);
        check(busy == 1'b1, "pp_busy", 32'(busy), 32'd1);
        wait_idle(1000);

        // Reset during WAIT_R with two commands queued
        push_cmd(8'h3C, 8'h4D, 2, 1);
        push_cmd(8'h5E, 8'h6F, 0, 0);
        push_cmd(8'h70, 8'h81, 0, 0);
        check(fifo_count == 3'd2, "mid_queued", 32'(fifo_count), 32'd2);
        cnt = 0;
        while (!(pre_ready && pre_data == 8'h3C) && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        check(pre_ready == 1'b1, "mid_reg_byte", 32'(pre_data), 32'h3C);
        repeat (2) @(negedge clk);
        check(busy == 1'b1, "mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset("midrst");
        exp_q.delete();
        resp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (pre_ready || busy) cnt++;
        end
        check(cnt == 0, "post_rst_quiet", 32'(cnt), 32'd0);
        check(fifo_count == 3'd0, "post_rst_count", 32'(fifo_count), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 25; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            cnt = $urandom_range(0, 9);
            fk  = (cnt < 7) ? 0 : ((cnt < 9) ? 1 : 2);
            push_cmd(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), fk, $urandom_range(0, 2));
        end
        wait_idle(5000);

        check(exp_q.size() == 0, "scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check(resp_q.size() == 0, "responses_empty", 32'(resp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
